// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-slot vending controller.
// Holds the controller state encoding, the accepted coin denominations
// and the coin-legality check used by the coin detector.

package vend_pkg;

  localparam int COIN_W = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } vend_state_e;

  localparam logic [COIN_W-1:0] COIN_1  = 6'd1;
  localparam logic [COIN_W-1:0] COIN_5  = 6'd5;
  localparam logic [COIN_W-1:0] COIN_10 = 6'd10;
  localparam logic [COIN_W-1:0] COIN_50 = 6'd50;

  // Only the four denominations the acceptor is calibrated for count as money.
  function automatic logic coin_is_legal(input logic [COIN_W-1:0] value);
    return (value == COIN_1)  || (value == COIN_5) ||
           (value == COIN_10) || (value == COIN_50);
  endfunction

endpackage

// File: rtl/vend_coin_detect.sv
// Coin event detector: remembers last cycle's coin_input so that a coin
// held on the bus for several cycles is counted once, while a different
// nonzero value on the very next cycle counts as a fresh coin.

module vend_coin_detect
  import vend_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [COIN_W-1:0] coin_input,
  output logic              coin_evt,
  output logic              coin_legal,
  output logic [COIN_W-1:0] coin_val
);

  logic [COIN_W-1:0] coin_hist_q;

  // Coin history register, cleared by reset so the first coin after reset always counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      coin_hist_q <= '0;
    end else begin
      coin_hist_q <= coin_input;
    end
  end

  // A coin event is a nonzero value that differs from what was on the bus last cycle.
  always_comb begin
    coin_evt   = (coin_input != '0) && (coin_input != coin_hist_q);
    coin_legal = coin_is_legal(coin_input);
    coin_val   = coin_input;
  end

endmodule

// File: rtl/vend_fsm_multi.sv
// Multi-slot vending controller: credit accumulation with saturation,
// per-slot prices and stock counters, coin rejection, refund and
// dispense sequencing.
// Optional feature macro: VEND_CHANGE_EN -- when defined the remainder
// after a sale is paid out through CHANGE; otherwise it stays as credit.

module vend_fsm_multi
  import vend_pkg::*;
#(
  parameter int                          N_DRINKS   = 4,
  parameter int                          CREDIT_W   = 8,
  parameter logic [N_DRINKS*CREDIT_W-1:0] PRICE_LIST = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int                          MAX_CREDIT = 200,
  parameter int                          STOCK_W    = 4,
  parameter int                          STOCK_INIT = 8,
  localparam int                         IDX_W      = $clog2(N_DRINKS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COIN_W-1:0]   coin_input,
  input  logic [IDX_W:0]      drink_choose,
  input  logic                refund,
  input  logic                restock,
  output logic [IDX_W:0]      drink_output,
  output logic [CREDIT_W-1:0] coin_total,
  output logic [CREDIT_W-1:0] change_out,
  output logic                change_valid,
  output logic                coin_reject,
  output logic                deny,
  output logic [N_DRINKS-1:0] sold_out
);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q [N_DRINKS];
  logic [STOCK_W-1:0]  stock_d [N_DRINKS];
  logic [IDX_W:0]      drink_q, drink_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                change_valid_q, change_valid_d;
  logic                reject_q, reject_d;
  logic                deny_q, deny_d;

  logic                coin_evt;
  logic                coin_legal;
  logic [COIN_W-1:0]   coin_val;

  logic                req;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_in_range;
  logic [CREDIT_W-1:0] sel_price;
  logic [STOCK_W-1:0]  sel_stock;
  logic                sel_ok;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;

  vend_coin_detect u_coin_detect (
    .clk        (clk),
    .reset      (reset),
    .coin_input (coin_input),
    .coin_evt   (coin_evt),
    .coin_legal (coin_legal),
    .coin_val   (coin_val)
  );

  // Decode the selection: look up price and stock of the requested slot and
  // decide whether the purchase can go ahead with the current credit.
  always_comb begin
    req          = drink_choose[IDX_W];
    sel_idx      = drink_choose[IDX_W-1:0];
    sel_in_range = 1'b0;
    sel_price    = '0;
    sel_stock    = '0;
    for (int i = 0; i < N_DRINKS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_in_range = 1'b1;
        sel_price    = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
        sel_stock    = stock_q[i];
      end
    end
    sel_ok = sel_in_range && (sel_stock != '0) && (credit_q >= sel_price);
  end

  // Credit-plus-coin is formed one bit wider so a sum past MAX_CREDIT is
  // caught before it could wrap the credit register.
  always_comb begin
    coin_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
    coin_fits = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
  end

  // Next-state and output logic. Priority inside IDLE/CREDIT is refund,
  // then request, then coin; any coin that is not the winning event is rejected.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    stock_d        = stock_q;
    drink_d        = '0;
    change_d       = '0;
    change_valid_d = 1'b0;
    reject_d       = 1'b0;
    deny_d         = 1'b0;

    case (state_q)
      IDLE, CREDIT: begin
        if (refund && (state_q == CREDIT)) begin
          state_d        = CHANGE;
          change_d       = credit_q;
          change_valid_d = 1'b1;
          reject_d       = coin_evt;
        end else if (req) begin
          reject_d = coin_evt;
          if (sel_ok) begin
            state_d  = DISPENSE;
            drink_d  = {1'b1, sel_idx};
            credit_d = credit_q - sel_price;
            for (int i = 0; i < N_DRINKS; i++) begin
              if (sel_idx == IDX_W'(i)) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
              end
            end
          end else begin
            deny_d = 1'b1;
          end
        end else if (coin_evt) begin
          if (coin_legal && coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      DISPENSE: begin
        reject_d = coin_evt;
`ifdef VEND_CHANGE_EN
        if (credit_q != '0) begin
          state_d        = CHANGE;
          change_d       = credit_q;
          change_valid_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = (credit_q != '0) ? CREDIT : IDLE;
`endif
      end

      CHANGE: begin
        reject_d = coin_evt;
        credit_d = '0;
        state_d  = IDLE;
      end

      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase

    if (restock) begin
      for (int i = 0; i < N_DRINKS; i++) begin
        stock_d[i] = STOCK_W'(STOCK_INIT);
      end
    end
  end

  // State, credit, stock and registered output pulses; reset forfeits credit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      drink_q        <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      reject_q       <= 1'b0;
      deny_q         <= 1'b0;
      for (int i = 0; i < N_DRINKS; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      drink_q        <= drink_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      reject_q       <= reject_d;
      deny_q         <= deny_d;
      for (int i = 0; i < N_DRINKS; i++) begin
        stock_q[i] <= stock_d[i];
      end
    end
  end

  // Sold-out flags come straight from the stock registers so the panel
  // lights change in the same cycle the counter reaches zero.
  always_comb begin
    for (int i = 0; i < N_DRINKS; i++) begin
      sold_out[i] = (stock_q[i] == '0);
    end
  end

  assign drink_output = drink_q;
  assign coin_total   = credit_q;
  assign change_out   = change_q;
  assign change_valid = change_valid_q;
  assign coin_reject  = reject_q;
  assign deny         = deny_q;

endmodule

// File: tb/tb_vend_fsm_multi.sv
// Self-checking bench for vend_fsm_multi: directed scenarios plus
// randomized operations against a transaction-level vending model.
// Expected pulses are queued per kind and consumed by a monitor.

module tb_vend_fsm_multi;

  localparam int SINIT = 2;
  localparam int MAXC  = 200;
`ifdef VEND_CHANGE_EN
  localparam bit CHANGE_EN = 1'b1;
`else
  localparam bit CHANGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] coin_input;
  logic [2:0] drink_choose;
  logic       refund;
  logic       restock;
  logic [2:0] drink_output;
  logic [7:0] coin_total;
  logic [7:0] change_out;
  logic       change_valid;
  logic       coin_reject;
  logic       deny;
  logic [3:0] sold_out;

  int compared   = 0;
  int mismatched = 0;

  int prices [4] = '{10, 15, 20, 25};
  int mCredit;
  int mStock [4];
  int drinkQ[$];
  int denyQ[$];
  int rejectQ[$];
  int changeQ[$];

  vend_fsm_multi #(.STOCK_INIT(SINIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_input   (coin_input),
    .drink_choose (drink_choose),
    .refund       (refund),
    .restock      (restock),
    .drink_output (drink_output),
    .coin_total   (coin_total),
    .change_out   (change_out),
    .change_valid (change_valid),
    .coin_reject  (coin_reject),
    .deny         (deny),
    .sold_out     (sold_out)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareValue(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every output pulse must match the oldest expectation of its kind.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (drink_output[2]) begin
        if (drinkQ.size() == 0) compareValue("unexpected drink_output idx", int'(drink_output[1:0]), -1);
        else compareValue("drink_output idx", int'(drink_output[1:0]), drinkQ.pop_front());
      end
      if (deny) begin
        compareValue("deny expected", int'(denyQ.size() > 0), 1);
        if (denyQ.size() > 0) void'(denyQ.pop_front());
      end
      if (coin_reject) begin
        compareValue("coin_reject expected", int'(rejectQ.size() > 0), 1);
        if (rejectQ.size() > 0) void'(rejectQ.pop_front());
      end
      if (change_valid) begin
        if (changeQ.size() == 0) compareValue("unexpected change_out", int'(change_out), -1);
        else compareValue("change_out", int'(change_out), changeQ.pop_front());
      end
    end
  end

  function automatic void modelReset();
    mCredit = 0;
    foreach (mStock[i]) mStock[i] = SINIT;
  endfunction

  function automatic void modelCoin(input int v);
    if (v == 0) return;
    if ((v == 1 || v == 5 || v == 10 || v == 50) && (mCredit + v <= MAXC)) mCredit += v;
    else rejectQ.push_back(1);
  endfunction

  // One settled-machine operation: refund beats request beats coin.
  function automatic void modelStep(input int coin, input bit req, input int idx,
                                    input bit rf, input bit rs);
    if (rf && mCredit > 0) begin
      if (coin != 0) rejectQ.push_back(1);
      changeQ.push_back(mCredit);
      mCredit = 0;
    end else if (req) begin
      if (coin != 0) rejectQ.push_back(1);
      if (mStock[idx] == 0 || mCredit < prices[idx]) begin
        denyQ.push_back(1);
      end else begin
        drinkQ.push_back(idx);
        mCredit -= prices[idx];
        mStock[idx]--;
        if (CHANGE_EN && mCredit > 0) begin
          changeQ.push_back(mCredit);
          mCredit = 0;
        end
      end
    end else begin
      modelCoin(coin);
    end
    if (rs) foreach (mStock[i]) mStock[i] = SINIT;
  endfunction

  task automatic driveOnly(input int coin, input bit req, input int idx,
                           input bit rf, input bit rs);
    coin_input   = 6'(coin);
    drink_choose = {req, 2'(idx)};
    refund       = rf;
    restock      = rs;
    @(posedge clk);
    #1;
    coin_input   = '0;
    drink_choose = '0;
    refund       = 1'b0;
    restock      = 1'b0;
  endtask

  task automatic applyStimulus(input int coin, input bit req, input int idx,
                               input bit rf, input bit rs);
    modelStep(coin, req, idx, rf, rs);
    driveOnly(coin, req, idx, rf, rs);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Compare settled credit, sold-out flags and drained expectation queues.
  task automatic checkOutput(input string tag);
    int expSold;
    @(negedge clk);
    expSold = 0;
    foreach (mStock[i]) if (mStock[i] == 0) expSold |= (1 << i);
    compareValue({tag, " coin_total"}, int'(coin_total), mCredit);
    compareValue({tag, " sold_out"}, int'(sold_out), expSold);
    compareValue({tag, " pending pulses"},
                 drinkQ.size() + denyQ.size() + rejectQ.size() + changeQ.size(), 0);
  endtask

  task automatic coin(input int v);
    applyStimulus(v, 1'b0, 0, 1'b0, 1'b0);
    settle();
  endtask

  task automatic resetDut();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    drinkQ.delete();
    denyQ.delete();
    rejectQ.delete();
    changeQ.delete();
  endtask

  initial begin
    int coinTable [10] = '{0, 0, 1, 5, 10, 50, 50, 3, 7, 63};
    reset        = 1'b1;
    coin_input   = '0;
    drink_choose = '0;
    refund       = 1'b0;
    restock      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetDut();

    @(negedge clk);
    compareValue("reset coin_total", int'(coin_total), 0);
    compareValue("reset drink_output", int'(drink_output), 0);
    compareValue("reset change_valid", int'(change_valid), 0);
    compareValue("reset pulses", int'({coin_reject, deny}), 0);
    compareValue("reset sold_out", int'(sold_out), 0);

    $display("[TB] coffee purchase with remainder");
    coin(10); coin(1); coin(10);
    applyStimulus(0, 1'b1, 2, 1'b0, 1'b0);
    @(negedge clk);
    compareValue("coffee drink_output", int'(drink_output), 3'b110);
    compareValue("coffee remainder", int'(coin_total), 1);
`ifdef VEND_CHANGE_EN
    @(negedge clk);
    compareValue("coffee change_valid", int'(change_valid), 1);
`endif
    settle();
    checkOutput("coffee");
    compareValue("coffee final credit", int'(coin_total), CHANGE_EN ? 0 : 1);

    $display("[TB] reset forfeits credit, then exact milk");
    resetDut();
    coin(5); coin(10);
    resetDut();
    @(negedge clk);
    compareValue("reset clears credit", int'(coin_total), 0);
    coin(10); coin(10);
    repeat (5) coin(1);
    applyStimulus(0, 1'b1, 3, 1'b0, 1'b0);
    @(negedge clk);
    compareValue("milk drink_output", int'(drink_output), 3'b111);
    settle();
    checkOutput("milk");

    $display("[TB] insufficient credit deny");
    resetDut();
    coin(10);
    applyStimulus(0, 1'b1, 3, 1'b0, 1'b0);
    @(negedge clk);
    compareValue("deny pulse", int'(deny), 1);
    compareValue("deny credit kept", int'(coin_total), 10);
    compareValue("deny no drink", int'(drink_output), 0);
    settle();
    checkOutput("deny");

    $display("[TB] stock exhaustion and restock");
    resetDut();
    repeat (3) begin
      coin(10);
      applyStimulus(0, 1'b1, 0, 1'b0, 1'b0);
      settle();
    end
    checkOutput("soldout");
    compareValue("tea sold_out", int'(sold_out[0]), 1);
    applyStimulus(0, 1'b0, 0, 1'b0, 1'b1);
    settle();
    checkOutput("restock");
    compareValue("tea restocked", int'(sold_out[0]), 0);

    $display("[TB] credit ceiling");
    resetDut();
    coin(50); coin(50); coin(50);
    repeat (4) coin(10);
    compareValue("credit 190", int'(coin_total), 190);
    coin(50);
    checkOutput("overflow");
    coin(10);
    checkOutput("ceiling");
    compareValue("credit 200", int'(coin_total), 200);
    coin(3);
    checkOutput("illegal");

    $display("[TB] refund beats request");
    resetDut();
    coin(10); coin(10); coin(10); coin(5);
    applyStimulus(0, 1'b1, 1, 1'b1, 1'b0);
    settle();
    checkOutput("refund");
    compareValue("refund credit", int'(coin_total), 0);

    $display("[TB] held coin, coin pairs, back-to-back requests");
    resetDut();
    modelCoin(10);
    coin_input = 6'd10;
    repeat (4) @(posedge clk);
    #1;
    coin_input = '0;
    settle();
    checkOutput("held coin");
    modelCoin(5);
    modelCoin(1);
    coin_input = 6'd5;
    @(posedge clk);
    #1;
    coin_input = 6'd1;
    @(posedge clk);
    #1;
    coin_input = '0;
    settle();
    checkOutput("coin pair");
    applyStimulus(0, 1'b1, 0, 1'b0, 1'b0);
    rejectQ.push_back(1);
    driveOnly(5, 1'b1, 0, 1'b0, 1'b0);
    settle();
    checkOutput("back-to-back");

    $display("[TB] randomized operations");
    resetDut();
    for (int n = 0; n < 300; n++) begin
      int c;
      bit r, rf, rs;
      int idx;
      c   = coinTable[$urandom_range(0, 9)];
      r   = ($urandom_range(0, 99) < 35);
      idx = $urandom_range(0, 3);
      rf  = ($urandom_range(0, 99) < 8);
      rs  = ($urandom_range(0, 99) < 5);
      applyStimulus(c, r, idx, rf, rs);
      settle();
      checkOutput("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
